rr_counter_arbiter: RTL
=======================

// Module: rr_counter_arbiter
// PURPOSE
//  Round-robin arbiter sharing one resource among 4 requesters.
//  A 2-bit sync up pointer counter sets the priority start point; it advances past each winner.
//  Grants are registered and one-hot, with a hold-time limit that forces preemption.
//  Sits between requester blocks and a shared counter/datapath resource.
// PARAMETERS
//  MAX_HOLD  8  max cycles a grant is held while another requester waits; legal range >=1
//  HOLD_W    derived localparam = $clog2(MAX_HOLD+1); width of hold_cnt
// PORTS
//  clk        in   1       clock, rising edge
//  reset      in   1       asynchronous, active-high
//  req        in   4       request levels, one per requester, held until served
//  gnt        out  4       one-hot grant, registered
//  gnt_valid  out  1       |gnt
//  gnt_id     out  2       index of granted requester; valid when gnt_valid=1
//  hold_cnt   out  HOLD_W  cycles current grant has been held; 1 on first grant cycle
//  preempt    out  1       1-cycle pulse when a grant is revoked by the hold limit
//  lock       in   1       present only with ARB_LOCK_EN
// BEHAVIOUR
//  Reset
//   - Asynchronous clear, effective immediately, also mid-grant.
//   - Sets gnt=0, gnt_valid=0, gnt_id=0, hold_cnt=0, preempt=0, ptr=0, state=IDLE.
//  States
//   - IDLE: gnt=0; if |req, winner = first set req[(ptr+i)%4], i=0..3.
//     Next edge: gnt[winner]=1, gnt_id=winner, hold_cnt=1, state=GRANT.
//   - GRANT, release: req[gnt_id]=0 -> next edge gnt=0, hold_cnt=0,
//     ptr=(gnt_id+1)%4, state=IDLE.
//   - GRANT, preempt: hold_cnt==MAX_HOLD and another req bit set ->
//     next edge gnt=0, hold_cnt=0, ptr=(gnt_id+1)%4, preempt=1 for that cycle, state=IDLE.
//   - GRANT, hold: otherwise hold_cnt increments, saturating at MAX_HOLD.
//  Latency and gaps
//   - req to gnt is 1 cycle from IDLE.
//   - At least one gnt=0 cycle separates any two grants, including same-requester re-grants.
//  Boundary conditions
//   - ptr wraps 3->0; winner search wraps modulo 4.
//   - Release and hold limit in the same cycle: treated as release, preempt=0.
//   - Sole requester at hold limit: grant continues; hold_cnt stays MAX_HOLD.
//   - req changes of non-granted bits during GRANT: no effect until the next IDLE arbitration.
//   - Invariant: gnt is always one-hot or zero.
// CONFIGURATION
//  ARB_LOCK_EN defined
//   - Adds input lock.
//   - lock=1 in GRANT suppresses preemption; hold_cnt still saturates.
//   - Release still honoured.
//   - lock is ignored in IDLE.
//  ARB_LOCK_EN undefined
//   - No lock port; preemption is always active.
// TESTING
//  1. Reset while gnt=4'b0100 -> gnt=0, gnt_id=0, hold_cnt=0 with no clock edge; first grant after reset favours req0.
//  2. req=4'b1111 held; each winner drops req after 2 grant cycles -> grant order 0,1,2,3,0, each gnt separated by 1 idle cycle.
//  3. Only req3, dropped and reasserted, with ptr=3 -> gnt=4'b1000, then ptr=0; next req=4'b1001 -> gnt=4'b0001 (wrap).
//  4. req0 held forever, req2 asserted, MAX_HOLD=8 -> gnt0 for 8 cycles, preempt pulse, idle cycle, gnt=4'b0100.
//  5. req1 alone held 20 cycles -> gnt=4'b0010 continuous, hold_cnt saturates at 8, preempt never asserted.
//  6. ARB_LOCK_EN, lock=1, req=4'b0011 -> gnt0 held past 8 cycles; lock=0 -> preempt next edge, then gnt=4'b0010.

Source files
------------

// File: rtl/rr_counter_arbiter.sv
// Four-way round-robin arbiter with registered one-hot grants and a hold-time limit that preempts long grants.
// Optional macro ARB_LOCK_EN adds a 'lock' input that suppresses preemption while a grant is held.
module rr_counter_arbiter #(
    parameter  int MAX_HOLD = 8,
    localparam int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic              clk,
    input  logic              reset,
`ifdef ARB_LOCK_EN
    input  logic              lock,
`endif
    input  logic [3:0]        req,
    output logic [3:0]        gnt,
    output logic              gnt_valid,
    output logic [1:0]        gnt_id,
    output logic [HOLD_W-1:0] hold_cnt,
    output logic              preempt
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state, state_n;
    logic [3:0]        gnt_n;
    logic [1:0]        gnt_id_n;
    logic [HOLD_W-1:0] hold_n;
    logic [1:0]        ptr, ptr_n;
    logic              preempt_n;
    logic [1:0]        winner;
    logic [1:0]        idx;
    logic              found;
    logic              lock_active;
    logic              others_waiting;

`ifdef ARB_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    assign gnt_valid      = |gnt;
    assign others_waiting = |(req & ~gnt);

    // First requester found scanning upward from ptr, wrapping modulo 4
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        hold_n    = hold_cnt;
        ptr_n     = ptr;
        preempt_n = 1'b0;
        case (state)
            IDLE: begin
                gnt_n  = '0;
                hold_n = '0;
                if (found) begin
                    gnt_n    = 4'b0001 << winner;
                    gnt_id_n = winner;
                    hold_n   = HOLD_W'(1);
                    state_n  = GRANT;
                end
            end
            GRANT: begin
                // Release takes precedence over the hold limit
                if (!req[gnt_id]) begin
                    gnt_n   = '0;
                    hold_n  = '0;
                    ptr_n   = gnt_id + 2'd1;
                    state_n = IDLE;
                end else if (hold_cnt == HOLD_MAX && others_waiting && !lock_active) begin
                    gnt_n     = '0;
                    hold_n    = '0;
                    ptr_n     = gnt_id + 2'd1;
                    preempt_n = 1'b1;
                    state_n   = IDLE;
                end else if (hold_cnt != HOLD_MAX) begin
                    hold_n = hold_cnt + HOLD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            hold_cnt <= '0;
            ptr      <= '0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            hold_cnt <= hold_n;
            ptr      <= ptr_n;
            preempt  <= preempt_n;
        end
    end

endmodule
